gpu_fill_engine: RTL and testbench
==================================

// Module: gpu_fill_engine
// PURPOSE
//  Rectangle-fill rasterizer directly downstream of gpu_controller.
//  Consumes the controller's fill command (run_fill/x1..y2_fill, r/g/b)
//  and emits one pixel-write per covered pixel to the frame-buffer write
//  port, with a valid/ready handshake. Reports completion on
//  finished_fill_o, which the controller waits on before its next pop.
// PARAMETERS
//  W_BITS    `WIDTH_BITS    x-coordinate width
//  H_BITS    `HEIGHT_BITS   y-coordinate width
//  C_BITS    `CHANNEL_BITS  colour channel width
//  SCREEN_W  640            visible width; x clipped to SCREEN_W-1
//  SCREEN_H  480            visible height; y clipped to SCREEN_H-1
// PORTS
//  clk              in   1       system clock, rising edge
//  n_rst            in   1       asynchronous active-low reset
//  run_fill_i       in   1       fill request from controller (level)
//  x1_fill_i        in   W_BITS  corner A x
//  y1_fill_i        in   H_BITS  corner A y
//  x2_fill_i        in   W_BITS  corner B x
//  y2_fill_i        in   H_BITS  corner B y
//  r_i/g_i/b_i      in   C_BITS  fill colour
//  px_ready_i       in   1       frame-buffer port accepts write this cycle
//  px_write_o       out  1       pixel write valid
//  px_x_o           out  W_BITS  pixel x
//  px_y_o           out  H_BITS  pixel y
//  px_r_o/g_o/b_o   out  C_BITS  pixel colour
//  busy_o           out  1       high in any state other than IDLE
//  finished_fill_o  out  1       one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; run_prev=1, so a request held through
//   reset does not start a fill. Async assert, sync release.
//  Start: rising edge of run_fill_i (run_fill_i & ~run_prev) while in IDLE.
//   All inputs are latched on that edge.
//   Edges outside IDLE are ignored.
//  States:
//   IDLE  -> SETUP on start.
//   SETUP (1 cycle): xmin=min(x1,x2), xmax=max(x1,x2), same for y;
//    xmax=min(xmax,SCREEN_W-1), ymax=min(ymax,SCREEN_H-1).
//    If xmin>=SCREEN_W or ymin>=SCREEN_H -> DONE (zero writes),
//    else -> EMIT with cx=xmin, cy=ymin.
//   EMIT: px_write_o=1, px_x_o=cx, px_y_o=cy, colour=latched r/g/b.
//    On clk with px_ready_i=1 the pixel is accepted:
//     cx<xmax -> cx++
//     else cx=xmin; then cy<ymax -> cy++, else -> DONE.
//    With px_ready_i=0, all px_* outputs hold; no skip, no duplicate.
//   DONE (1 cycle): finished_fill_o=1, px_write_o=0 -> IDLE.
//  Latency: start edge sampled at edge N; SETUP in cycle N+1; first
//   px_write_o in cycle N+2. Throughput is 1 pixel/cycle while
//   px_ready_i=1. finished_fill_o is high the cycle after the last accept.
//  Pixel count = (xmax-xmin+1)*(ymax-ymin+1), row-major, left to right,
//   top row first. Degenerate rectangles (x1==x2 and/or y1==y2) give a
//   single row, column or pixel.
//  Counter compares use full W_BITS/H_BITS. cx/cy never exceed xmax/ymax,
//   so no wrap-around.
//  Request semantics: run_fill_i may stay high after finished_fill_o.
//   A new fill requires the input to go low and then high again.
//  Reset mid-fill: aborts immediately; no further writes and no
//   finished_fill_o pulse.
// TESTING
//  1. (2,3)-(4,4), rgb 10/9/8, ready=1 -> writes (2,3)(3,3)(4,3)(2,4)(3,4)(4,4)
//     with rgb 10/9/8. First write 2 cycles after the edge; finished on cycle 9.
//  2. Swapped corners (4,4)-(2,3) -> identical sequence and timing to test 1.
//  3. Test 1 with px_ready_i low for 3 cycles while (3,3) is presented ->
//     (3,3) held stable for 4 cycles; 6 writes total; no duplicates.
//  4. Clipping: (630,470)-(700,500) -> 100 writes, x 630..639, y 470..479.
//     (700,10)-(710,20) -> 0 writes; finished pulse in cycle N+2.
//  5. Controller handshake: fill (15,150)-(299,250) with run held high until
//     finished, then high 3 more cycles -> 285*101=28785 writes, one
//     finished pulse, no restart.
//  6. n_rst pulsed low mid-fill with run_fill_i held high -> outputs 0
//     asynchronously; no finished pulse and no restart until run drops
//     and rises again.

Source files
------------

// File: rtl/gpu_fill_engine.sv
// Rectangle-fill rasterizer: turns one latched fill command into a row-major stream of pixel writes.
// Latency: start edge at clock N, SETUP in cycle N+1, first pixel write in cycle N+2, then 1 pixel/cycle.
// Backpressure: px_ready_i low freezes the presented pixel; finished_fill_o pulses the cycle after the last accept.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_fill_engine #(
    parameter int W_BITS   = `WIDTH_BITS,
    parameter int H_BITS   = `HEIGHT_BITS,
    parameter int C_BITS   = `CHANNEL_BITS,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              run_fill_i,
    input  logic [W_BITS-1:0] x1_fill_i,
    input  logic [H_BITS-1:0] y1_fill_i,
    input  logic [W_BITS-1:0] x2_fill_i,
    input  logic [H_BITS-1:0] y2_fill_i,
    input  logic [C_BITS-1:0] r_i,
    input  logic [C_BITS-1:0] g_i,
    input  logic [C_BITS-1:0] b_i,
    input  logic              px_ready_i,
    output logic              px_write_o,
    output logic [W_BITS-1:0] px_x_o,
    output logic [H_BITS-1:0] px_y_o,
    output logic [C_BITS-1:0] px_r_o,
    output logic [C_BITS-1:0] px_g_o,
    output logic [C_BITS-1:0] px_b_o,
    output logic              busy_o,
    output logic              finished_fill_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last visible column/row, and the first off-screen coordinate (one bit wider so it is representable).
    localparam logic [W_BITS-1:0] X_LIM = W_BITS'(SCREEN_W - 1);
    localparam logic [H_BITS-1:0] Y_LIM = H_BITS'(SCREEN_H - 1);
    localparam logic [W_BITS:0]   X_END = (W_BITS + 1)'(SCREEN_W);
    localparam logic [H_BITS:0]   Y_END = (H_BITS + 1)'(SCREEN_H);

    state_t state, state_nxt;

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic              run_prev;
    logic              start;

    logic [W_BITS-1:0] xa, xb, xmin, xmax, cx;
    logic [H_BITS-1:0] ya, yb, ymin, ymax, cy;
    logic [C_BITS-1:0] r_q, g_q, b_q;

    logic [W_BITS-1:0] x_lo, x_hi, x_hi_clip;
    logic [H_BITS-1:0] y_lo, y_hi, y_hi_clip;
    logic              off_screen;
    logic              more_cols, more_rows;
    logic              write_en, finish_en;

    // Reset asserts immediately but is released only on a clock edge, so no flop sees a release near its edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    // Only a fresh low-to-high transition of the request starts a fill, and only from IDLE.
    assign start = (state == IDLE) && run_fill_i && !run_prev;

    // Normalise the corners and clip the far edge to the visible screen.
    assign x_lo       = (xa < xb) ? xa : xb;
    assign x_hi       = (xa < xb) ? xb : xa;
    assign y_lo       = (ya < yb) ? ya : yb;
    assign y_hi       = (ya < yb) ? yb : ya;
    assign x_hi_clip  = (x_hi > X_LIM) ? X_LIM : x_hi;
    assign y_hi_clip  = (y_hi > Y_LIM) ? Y_LIM : y_hi;
    assign off_screen = ({1'b0, x_lo} >= X_END) || ({1'b0, y_lo} >= Y_END);

    assign more_cols = cx < xmax;
    assign more_rows = cy < ymax;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state output strobes.
    always_comb begin
        state_nxt = state;
        write_en  = 1'b0;
        finish_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = off_screen ? DONE : EMIT;
            end
            EMIT: begin
                write_en = 1'b1;
                if (px_ready_i && !more_cols && !more_rows) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                finish_en = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, bounds setup and the raster walk; cursor only moves on an accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_prev <= 1'b1;
            xa       <= '0;
            xb       <= '0;
            ya       <= '0;
            yb       <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            xmin     <= '0;
            xmax     <= '0;
            ymin     <= '0;
            ymax     <= '0;
            cx       <= '0;
            cy       <= '0;
        end else begin
            run_prev <= run_fill_i;
            if (start) begin
                xa  <= x1_fill_i;
                xb  <= x2_fill_i;
                ya  <= y1_fill_i;
                yb  <= y2_fill_i;
                r_q <= r_i;
                g_q <= g_i;
                b_q <= b_i;
            end
            if (state == SETUP) begin
                xmin <= x_lo;
                xmax <= x_hi_clip;
                ymin <= y_lo;
                ymax <= y_hi_clip;
                cx   <= x_lo;
                cy   <= y_lo;
            end
            if (state == EMIT && px_ready_i) begin
                if (more_cols) begin
                    cx <= cx + 1'b1;
                end else begin
                    cx <= xmin;
                    if (more_rows) begin
                        cy <= cy + 1'b1;
                    end
                end
            end
        end
    end

    assign px_write_o      = write_en;
    assign px_x_o          = cx;
    assign px_y_o          = cy;
    assign px_r_o          = r_q;
    assign px_g_o          = g_q;
    assign px_b_o          = b_q;
    assign busy_o          = (state != IDLE);
    assign finished_fill_o = finish_en;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Directed bench for gpu_fill_engine: expected pixels are queued when a fill is launched and
// compared against every presented write; timing, counts, stalls, clipping and reset are checked.

module tb_gpu_fill_engine;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       run;
    logic [9:0] x1, x2;
    logic [8:0] y1, y2;
    logic [7:0] r, g, b;
    logic       ready;
    logic       px_write;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic [7:0] pr, pg, pb;
    logic       busy;
    logic       fin;

    int total      = 0;
    int passed     = 0;
    int cyc        = 0;
    int wr_cnt     = 0;
    int fin_cnt    = 0;
    int fin_cyc    = -1;
    int first_cyc  = -1;
    int fin_before = 0;
    int pres33     = 0;
    bit track33    = 1'b0;
    logic [42:0] q[$];

    gpu_fill_engine #(
        .W_BITS(10), .H_BITS(9), .C_BITS(8), .SCREEN_W(640), .SCREEN_H(480)
    ) dut (
        .clk(clk), .n_rst(n_rst), .run_fill_i(run),
        .x1_fill_i(x1), .y1_fill_i(y1), .x2_fill_i(x2), .y2_fill_i(y2),
        .r_i(r), .g_i(g), .b_i(b), .px_ready_i(ready),
        .px_write_o(px_write), .px_x_o(px_x), .px_y_o(px_y),
        .px_r_o(pr), .px_g_o(pg), .px_b_o(pb),
        .busy_o(busy), .finished_fill_o(fin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Scoreboard: every presented write must match the queue head; it is popped only when accepted.
    always @(negedge clk) begin
        if (px_write) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (track33 && px_x == 10'd3 && px_y == 9'd3) pres33++;
            if (q.size() == 0) begin
                check("unexpected_write", q.size(), 1);
            end else begin
                check("pixel", {21'd0, px_x, px_y, pr, pg, pb}, {21'd0, q[0]});
                if (ready) begin
                    void'(q.pop_front());
                    wr_cnt++;
                end
            end
        end
        if (fin) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
    end

    task automatic start_fill(input int ax, input int ay, input int bx, input int by,
                              input int cr, input int cg, input int cb, output int n_edge);
        int xl, xh, yl, yh;
        @(posedge clk);
        #1;
        x1 = 10'(ax); y1 = 9'(ay); x2 = 10'(bx); y2 = 9'(by);
        r = 8'(cr); g = 8'(cg); b = 8'(cb);
        run = 1'b1;
        n_edge = cyc + 1;
        first_cyc = -1;
        wr_cnt = 0;
        fin_before = fin_cnt;
        xl = (ax < bx) ? ax : bx;
        xh = (ax < bx) ? bx : ax;
        yl = (ay < by) ? ay : by;
        yh = (ay < by) ? by : ay;
        if (xh > 639) xh = 639;
        if (yh > 479) yh = 479;
        if (xl < 640 && yl < 480) begin
            for (int yy = yl; yy <= yh; yy++)
                for (int xx = xl; xx <= xh; xx++)
                    q.push_back({10'(xx), 9'(yy), 8'(cr), 8'(cg), 8'(cb)});
        end
    endtask

    task automatic finish_fill(input string tag, input int n_edge, input int exp_writes,
                               input int stall, input int budget);
        int k;
        k = 0;
        while (fin_cnt == fin_before && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_fin_seen"}, fin_cnt, fin_before + 1);
        check({tag, "_writes"}, wr_cnt, exp_writes);
        check({tag, "_queue_left"}, q.size(), 0);
        if (exp_writes > 0) check({tag, "_first_write_cyc"}, first_cyc, n_edge + 1);
        check({tag, "_fin_cyc"}, fin_cyc, n_edge + 1 + exp_writes + stall);
        q.delete();
    endtask

    task automatic drop_run();
        @(posedge clk);
        #1;
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f;
        n_rst = 1'b0; run = 1'b1; ready = 1'b1;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; r = '0; g = '0; b = '0;

        // Reset with the request already high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_px_write", px_write, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", fin, 0);
        check("rst_px_x", px_x, 0);
        check("rst_px_y", px_y, 0);
        check("rst_px_r", pr, 0);
        @(negedge clk) n_rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("held_run_no_start_busy", busy, 0);
        check("held_run_no_start_fin", fin_cnt, 0);
        run = 1'b0;
        repeat (2) @(posedge clk);

        // Basic fill and swapped corners.
        start_fill(2, 3, 4, 4, 10, 9, 8, n);
        finish_fill("t1", n, 6, 0, 50);
        drop_run();
        start_fill(4, 4, 2, 3, 10, 9, 8, n);
        finish_fill("t2", n, 6, 0, 50);
        drop_run();

        // Backpressure while (3,3) is presented.
        start_fill(2, 3, 4, 4, 10, 9, 8, n);
        track33 = 1'b1;
        pres33 = 0;
        while (cyc < n + 2) begin
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready = 1'b1;
        finish_fill("t3", n, 6, 3, 50);
        check("t3_hold_cycles", pres33, 4);
        track33 = 1'b0;
        drop_run();

        // Clipping at the bottom-right corner, then a fully off-screen rectangle.
        start_fill(630, 470, 700, 500, 1, 2, 3, n);
        finish_fill("t4a", n, 100, 0, 300);
        drop_run();
        start_fill(700, 10, 710, 20, 4, 5, 6, n);
        finish_fill("t4b", n, 0, 0, 50);
        drop_run();

        // Large fill with the request held well past completion.
        start_fill(15, 150, 299, 250, 200, 100, 50, n);
        finish_fill("t5", n, 28785, 0, 30000);
        f = fin_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("t5_single_fin", fin_cnt, f);
        check("t5_no_restart", busy, 0);
        drop_run();

        // Reset in the middle of a fill, request kept high.
        start_fill(0, 0, 9, 9, 7, 7, 7, n);
        repeat (5) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("t6_async_write", px_write, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_x", px_x, 0);
        check("t6_async_r", pr, 0);
        q.delete();
        f = fin_cnt;
        @(negedge clk) n_rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_fin", fin_cnt, f);
        check("t6_no_restart", busy, 0);
        drop_run();
        start_fill(1, 1, 2, 1, 3, 3, 3, n);
        finish_fill("t6_refill", n, 2, 0, 50);
        drop_run();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
